// File: rtl/hart_mem_arbiter.sv
// hart_mem_arbiter: round-robin arbiter sharing one memory-controller data port among N_HARTS harts.
// Optional grant counter on w_grant_cnt enabled by defining HART_ARB_PERF_CNT_EN.
module hart_mem_arbiter #(
  parameter int N_HARTS = 2,
  localparam int ID_W = N_HARTS > 1 ? $clog2(N_HARTS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic [N_HARTS-1:0]     w_hart_req,
  input  logic [N_HARTS-1:0]     w_hart_we,
  input  logic [32*N_HARTS-1:0]  w_hart_addr,
  input  logic [32*N_HARTS-1:0]  w_hart_wdata,
  input  logic [3*N_HARTS-1:0]   w_hart_ctrl,
  output logic [N_HARTS-1:0]     w_hart_ack,
  output logic [127:0]           w_hart_rdata,
  output logic                   w_mc_req,
  output logic [31:0]            w_mc_addr,
  output logic [31:0]            w_mc_wdata,
  output logic [2:0]             w_mc_ctrl,
  output logic                   w_mc_we,
  input  logic                   w_mc_ready,
  input  logic                   w_mc_done,
  input  logic [127:0]           w_mc_rdata,
  output logic [ID_W-1:0]        w_grant_id,
  output logic                   w_arb_busy,
  output logic [31:0]            w_grant_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] r_last, pick, lo, hi;
  logic hi_hit;
  // Prefer the lowest requester above r_last; otherwise wrap to the lowest requester overall.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_hit = 1'b0;
    for (int i = N_HARTS - 1; i >= 0; i--) begin
      lo = w_hart_req[i] ? ID_W'(i) : lo;
      hi = (w_hart_req[i] && ID_W'(i) > r_last) ? ID_W'(i) : hi;
      hi_hit = hi_hit | (w_hart_req[i] && ID_W'(i) > r_last);
    end
    pick = hi_hit ? hi : lo;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (|w_hart_req ? ISSUE : IDLE) :
               state == ISSUE ? (w_mc_ready ? WAIT : ISSUE) :
               state == WAIT  ? (w_mc_done ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) begin
      r_last       <= ID_W'(N_HARTS - 1);
      w_grant_id   <= '0;
      w_mc_addr    <= '0;
      w_mc_wdata   <= '0;
      w_mc_ctrl    <= '0;
      w_mc_we      <= 1'b0;
      w_hart_rdata <= '0;
    end else begin
      if (state == IDLE && |w_hart_req) begin
        w_grant_id <= pick;
        w_mc_addr  <= w_hart_addr[32*pick +: 32];
        w_mc_wdata <= w_hart_wdata[32*pick +: 32];
        w_mc_ctrl  <= w_hart_ctrl[3*pick +: 3];
        w_mc_we    <= w_hart_we[pick];
      end
      if (state == WAIT && w_mc_done) w_hart_rdata <= w_mc_rdata;
      if (state == DONE) r_last <= w_grant_id;
    end
  assign w_mc_req   = state == ISSUE;
  assign w_arb_busy = state != IDLE;
  for (genvar g = 0; g < N_HARTS; g++) begin : g_ack
    assign w_hart_ack[g] = state == DONE && w_grant_id == ID_W'(g);
  end
`ifdef HART_ARB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) w_grant_cnt <= '0;
    else if (state == DONE) w_grant_cnt <= w_grant_cnt + 32'd1;
`else
  assign w_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_hart_mem_arbiter.sv
// tb_hart_mem_arbiter: randomized and directed bench with a transaction-timeline model of the arbiter.
module tb_hart_mem_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  logic CLK = 1'b0;
  logic RST_X;
  logic [N-1:0] req_p = '0, we_p = '0;
  logic [32*N-1:0] addr_p = '0, wdata_p = '0;
  logic [3*N-1:0] ctrl_p = '0;
  logic ready = 1'b0, done = 1'b0;
  logic [127:0] rdata_in = '0;
  logic [N-1:0] ack;
  logic [127:0] hrdata;
  logic mreq, mwe, busy;
  logic [31:0] maddr, mwdata, cnt;
  logic [2:0] mctrl;
  logic [IW-1:0] gid;

  hart_mem_arbiter #(.N_HARTS(N)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_hart_req(req_p), .w_hart_we(we_p), .w_hart_addr(addr_p),
    .w_hart_wdata(wdata_p), .w_hart_ctrl(ctrl_p), .w_hart_ack(ack), .w_hart_rdata(hrdata),
    .w_mc_req(mreq), .w_mc_addr(maddr), .w_mc_wdata(mwdata), .w_mc_ctrl(mctrl), .w_mc_we(mwe),
    .w_mc_ready(ready), .w_mc_done(done), .w_mc_rdata(rdata_in), .w_grant_id(gid),
    .w_arb_busy(busy), .w_grant_cnt(cnt));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, n = 0;
  bit act;
  int g, issue_end, done_cyc, ack_cyc, next_idle, win, last;
  logic [31:0] e_addr, e_wdata, e_cnt;
  logic [2:0] e_ctrl;
  logic e_we;
  int e_gid;
  logic [127:0] e_rdata;
  int f_rd = -1, f_dd = -1;
  bit f_rdata_en = 1'b0, stray = 1'b0;
  logic [127:0] f_rdata = '0;
  int mode = 0;
  int cd [N];
  int waitc [N];
  int grants [$];
  int acks = 0, req_seen = 0;
  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, a, e, n);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    act = 1'b0;
    last = N - 1;
    e_addr = '0; e_wdata = '0; e_ctrl = '0; e_we = 1'b0; e_gid = 0; e_rdata = '0; e_cnt = '0;
    for (int i = 0; i < N; i++) begin
      cd[i] = 0;
      waitc[i] = 0;
    end
  endtask

  task automatic zero_check(input string t);
    chk({t, "_ack"}, ack, 0);
    chk({t, "_rdata"}, hrdata, 0);
    chk({t, "_mreq"}, mreq, 0);
    chk({t, "_addr"}, maddr, 0);
    chk({t, "_wdata"}, mwdata, 0);
    chk({t, "_ctrl"}, mctrl, 0);
    chk({t, "_we"}, mwe, 0);
    chk({t, "_gid"}, gid, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_cnt"}, cnt, 0);
  endtask

  // Expected outputs follow from the transaction timeline: grant at g, ready at issue_end, done at done_cyc.
  task automatic verify();
    bit ex_busy, ex_req;
    logic [N-1:0] ex_ack;
    ex_busy = act && n > g && n <= ack_cyc;
    ex_req = act && n > g && n <= issue_end;
    ex_ack = (act && n == ack_cyc) ? N'(1) << win : '0;
    chk("busy", busy, ex_busy);
    chk("mc_req", mreq, ex_req);
    chk("ack", ack, ex_ack);
    chk("mc_addr", maddr, e_addr);
    chk("mc_wdata", mwdata, e_wdata);
    chk("mc_ctrl", mctrl, e_ctrl);
    chk("mc_we", mwe, e_we);
    chk("grant_id", gid, e_gid);
    chk("rdata", hrdata, e_rdata);
`ifdef HART_ARB_PERF_CNT_EN
    chk("grant_cnt", cnt, e_cnt);
`else
    chk("grant_cnt", cnt, 0);
`endif
    if (mreq) req_seen++;
  endtask

  task automatic step();
    int best, d, rd, dd;
    bit in_iss, in_wait;
    if (act && n == ack_cyc) begin
      req_p[win] = 1'b0;
      cd[win] = mode == 1 ? 2 : $urandom_range(0, 6);
      last = win;
      e_cnt = e_cnt + 32'd1;
      acks++;
    end
    if (mode != 0)
      for (int i = 0; i < N; i++) begin
        addr_p[32*i +: 32] = $urandom;
        wdata_p[32*i +: 32] = $urandom;
        ctrl_p[3*i +: 3] = 3'($urandom);
        we_p[i] = 1'($urandom);
        if (!req_p[i]) begin
          if (cd[i] > 0) cd[i]--;
          else if (mode == 1 || $urandom_range(0, 2) == 0) req_p[i] = 1'b1;
        end
      end
    if (n == next_idle) begin
      if (|req_p) begin
        best = N;
        win = 0;
        for (int i = 0; i < N; i++) begin
          d = (i - last - 1 + 2 * N) % N;
          if (req_p[i] && d < best) begin
            best = d;
            win = i;
          end
        end
        for (int i = 0; i < N; i++) if (req_p[i] && i != win) waitc[i]++;
        chk("fairness", waitc[win] <= N - 1, 1);
        waitc[win] = 0;
        grants.push_back(win);
        e_addr = addr_p[32*win +: 32];
        e_wdata = wdata_p[32*win +: 32];
        e_ctrl = ctrl_p[3*win +: 3];
        e_we = we_p[win];
        e_gid = win;
        rd = f_rd >= 0 ? f_rd : int'($urandom_range(0, 4));
        dd = f_dd >= 0 ? f_dd : int'($urandom_range(0, 3));
        act = 1'b1;
        g = n;
        issue_end = n + 1 + rd;
        done_cyc = issue_end + 1 + dd;
        ack_cyc = done_cyc + 1;
        next_idle = ack_cyc + 1;
      end else next_idle = n + 1;
    end
    in_iss = act && n > g && n < issue_end;
    in_wait = act && n > issue_end && n < done_cyc;
    ready = (act && n == issue_end) ? 1'b1 : in_iss ? 1'b0 : 1'($urandom);
    done = (act && n == done_cyc) ? 1'b1 : in_wait ? 1'b0 : stray ? 1'b1 : 1'($urandom);
    rdata_in = (act && n == done_cyc && f_rdata_en) ? f_rdata : rnd128();
    if (act && n == done_cyc) e_rdata = rdata_in;
    @(posedge CLK);
    #1;
    n++;
    verify();
  endtask

  initial begin
    RST_X = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge CLK);
      #1;
      n++;
      zero_check("rst");
    end
    RST_X = 1'b1;
    next_idle = n;

    f_rd = 0; f_dd = 0;
    req_p[0] = 1'b1; addr_p[31:0] = 32'h8000_0000; wdata_p[31:0] = 32'hDEAD_BEEF;
    ctrl_p[2:0] = 3'b010; we_p[0] = 1'b1;
    req_seen = 0;
    step();
    chk("sw_req", mreq, 1);
    chk("sw_addr", maddr, 32'h8000_0000);
    chk("sw_wdata", mwdata, 32'hDEAD_BEEF);
    chk("sw_ctrl", mctrl, 3'b010);
    chk("sw_we", mwe, 1);
    chk("sw_busy1", busy, 1);
    step();
    chk("sw_busy2", busy, 1);
    step();
    chk("sw_ack", ack, 4'b0001);
    chk("sw_busy3", busy, 1);
    step();
    chk("sw_idle", busy, 0);
    chk("sw_req_cycles", req_seen, 1);

    f_rd = 5; f_dd = 1;
    req_p[2] = 1'b1; addr_p[95:64] = 32'hA000_0040; wdata_p[95:64] = 32'h1234_5678;
    ctrl_p[8:6] = 3'b100; we_p[2] = 1'b0;
    req_seen = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("bp_req", mreq, 1);
      chk("bp_addr", maddr, 32'hA000_0040);
      chk("bp_ctrl", mctrl, 3'b100);
      chk("bp_noack", ack, 0);
      if (i < 5) step();
    end
    step();
    step();
    chk("bp_ack_early", ack, 0);
    step();
    chk("bp_ack", ack, 4'b0100);
    step();
    chk("bp_req_cycles", req_seen, 6);

    f_rd = 0; f_dd = 3; f_rdata_en = 1'b1;
    f_rdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    req_p[1] = 1'b1; addr_p[63:32] = 32'h0000_1000; we_p[1] = 1'b0;
    step();
    addr_p[63:32] = 32'h0000_2000;
    step();
    chk("latch_addr1", maddr, 32'h0000_1000);
    step();
    chk("latch_addr2", maddr, 32'h0000_1000);
    repeat (3) step();
    chk("rd_ack", ack, 4'b0010);
    chk("rd_data", hrdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    step();
    stray = 1'b1;
    repeat (3) step();
    chk("stray_busy", busy, 0);
    chk("stray_req", mreq, 0);
    chk("stray_rdata", hrdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    stray = 1'b0; f_rdata_en = 1'b0;

    f_rd = 0; f_dd = 4;
    req_p[3] = 1'b1; addr_p[127:96] = 32'h3000_0000;
    step();
    step();
    chk("mid_wait_busy", busy, 1);
    RST_X = 1'b0;
    #1;
    zero_check("rstw");
    @(posedge CLK);
    #1;
    n++;
    zero_check("rstw_hold");
    model_reset();
    req_p = 4'b0011;
    RST_X = 1'b1;
    next_idle = n;
    f_rd = -1; f_dd = -1; mode = 1;
    grants.delete();
    acks = 0;
    step();
    chk("rstw_grant0", gid, 0);
    chk("rstw_req", mreq, 1);
    for (int i = 0; i < 200 && acks < 3; i++) step();
    chk("cnt_reached", acks >= 3, 1);
`ifdef HART_ARB_PERF_CNT_EN
    chk("cnt3", cnt, 3);
`else
    chk("cnt0", cnt, 0);
`endif
    for (int i = 0; i < 400 && grants.size() < 6; i++) step();
    chk("rr_count", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", grants[i], rr_exp[i]);

    mode = 2;
    repeat (3000) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
